imem_loader_rom: RTL and testbench

Parametrised, loadable instruction memory for the 10-bit teaching CPU: a synchronous-read program store with a word-stream load port and a request/valid fetch port. It sits between the program loader (testbench or boot UART) and the CPU fetch stage. It replaces fixed, hard-coded program ROMs with one block whose contents are written at run time.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_ram.sv | 55 +++++
 rtl/imem_loader_rom.sv | 165 ++++++++++++++++
 tb/tb_imem_loader_rom.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared state encoding, halt word and parity helper for the
//               loadable instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

    // ISA halt instruction, returned for fetches past the loaded program
    localparam logic [9:0] C_HALT_WORD = 10'b0010000010;

    // Even-parity bit: the stored word plus this bit has an even number of ones
    function automatic logic parity_even(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_ram.sv
// ============================================================================
// Module      : imem_ram
// Description : Un-reset storage array, one synchronous write port and one
//               synchronous read port whose output holds when not reading.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ram #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

    // Callers never present addresses at or beyond DEPTH, so high bits are spare
    generate
        if (IDX_W < ADDR_W) begin : g_addr_pad
            logic w_unused_addr_bits;
            assign w_unused_addr_bits = &{1'b0, waddr[ADDR_W-1:IDX_W], raddr[ADDR_W-1:IDX_W]};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/imem_loader_rom.sv
// ============================================================================
// Module      : imem_loader_rom
// Description : Loadable program store: word-stream loader, 1-cycle fetch
//               port, range check and sticky fault flags.
//               Optional macro IMEM_PARITY_EN adds per-word even parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader_rom
    import imem_pkg::*;
#(
    parameter int               DATA_W    = 10,
    parameter int               ADDR_W    = 10,
    parameter int               DEPTH     = 1024,
    parameter logic [DATA_W-1:0] HALT_WORD = C_HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_busy,
    output logic [ADDR_W:0]   word_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              fault,
    output logic              parity_err
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);
    localparam logic [1:0]      SEL_NONE = 2'd0;
    localparam logic [1:0]      SEL_RAM  = 2'd1;
    localparam logic [1:0]      SEL_HALT = 2'd2;

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t          state_q, state_d;
    logic [ADDR_W:0] word_count_q, word_count_d;
    logic            fault_q, fault_d;
    logic            perr_q, perr_d;
    logic            read_valid_q, read_valid_d;
    logic [1:0]      sel_q, sel_d;

    logic            w_accept;
    logic            w_in_range;
    logic [ADDR_W:0] w_base;
    logic            w_load_act;
    logic            w_room;
    logic            w_perr_now;
    logic [MEM_W-1:0] w_wdata;
    logic [MEM_W-1:0] w_rdata;

    assign fetch_ready = (state_q == ST_RUN) && !load_start;
    assign w_accept    = fetch_req && fetch_ready;
    assign w_in_range  = {1'b0, fetch_addr} < word_count_q;

    // load_start restarts the pointer in the same cycle a word may arrive
    assign w_base     = load_start ? '0 : word_count_q;
    assign w_load_act = load_valid && (load_start || (state_q == ST_LOAD));
    assign w_room     = w_base < C_DEPTH;

`ifdef IMEM_PARITY_EN
    assign w_wdata    = {parity_even(32'(load_data)), load_data};
    assign w_perr_now = read_valid_q && (sel_q == SEL_RAM) &&
                        (parity_even(32'(w_rdata[DATA_W-1:0])) != w_rdata[DATA_W]);
`else
    assign w_wdata    = load_data;
    assign w_perr_now = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        fault_d      = fault_q;
        perr_d       = perr_q | w_perr_now;
        read_valid_d = w_accept;
        sel_d        = sel_q;

        if (load_start) begin
            state_d      = ST_LOAD;
            word_count_d = '0;
            fault_d      = 1'b0;
            perr_d       = 1'b0;
        end

        if (w_load_act) begin
            if (w_room) begin
                word_count_d = w_base + C_ONE;
            end else begin
                fault_d = 1'b1;
            end
            if (load_last) begin
                state_d = ST_RUN;
            end
        end

        if (w_accept) begin
            sel_d = w_in_range ? SEL_RAM : SEL_HALT;
            if (!w_in_range) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            word_count_q <= '0;
            fault_q      <= 1'b0;
            perr_q       <= 1'b0;
            read_valid_q <= 1'b0;
            sel_q        <= SEL_NONE;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            fault_q      <= fault_d;
            perr_q       <= perr_d;
            read_valid_q <= read_valid_d;
            sel_q        <= sel_d;
        end
    end

    imem_ram #(
        .WIDTH  (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_load_act && w_room),
        .waddr (w_base[ADDR_W-1:0]),
        .wdata (w_wdata),
        .re    (w_accept && w_in_range),
        .raddr (fetch_addr),
        .rdata (w_rdata)
    );

    // The RAM output is unreset, so the selector masks it until the first fetch
    always_comb begin
        read_data = '0;
        if (sel_q == SEL_RAM) begin
            read_data = w_rdata[DATA_W-1:0];
        end else if (sel_q == SEL_HALT) begin
            read_data = HALT_WORD;
        end
    end

    assign load_busy  = (state_q == ST_LOAD);
    assign word_count = word_count_q;
    assign read_valid = read_valid_q;
    assign fault      = fault_q;
    assign parity_err = perr_q | w_perr_now;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader_rom.sv
// ============================================================================
// Module      : tb_imem_loader_rom
// Description : Directed bench for imem_loader_rom with DEPTH=4; honours
//               IMEM_PARITY_EN for the parity corruption case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader_rom;

    localparam int         DATA_W = 10;
    localparam int         ADDR_W = 10;
    localparam int         DEPTH  = 4;
    localparam logic [9:0] HALT   = 10'b0010000010;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start, load_valid, load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_busy;
    logic [ADDR_W:0]   word_count;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              fault;
    logic              parity_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    imem_loader_rom #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_busy   (load_busy),
        .word_count  (word_count),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .fault       (fault),
        .parity_err  (parity_err)
    );

    typedef struct {
        logic       req;
        logic [9:0] addr;
        logic       exp_rv;
        logic [9:0] exp_rd;
        logic       exp_fault;
    } fvec_t;

    fvec_t fvec [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lw(input logic [9:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch_chk(input string nm, input logic [9:0] a,
                             input logic [9:0] exp_rd, input logic exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req  = 1'b0;
        chk({nm, "_rv"}, 32'(read_valid), 32'd1);
        chk({nm, "_rd"}, 32'(read_data), 32'(exp_rd));
        chk({nm, "_fault"}, 32'(fault), 32'(exp_fault));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_busy"},  32'(load_busy), 32'd0);
        chk({nm, "_wc"},    32'(word_count), 32'd0);
        chk({nm, "_ready"}, 32'(fetch_ready), 32'd0);
        chk({nm, "_rd"},    32'(read_data), 32'd0);
        chk({nm, "_rv"},    32'(read_valid), 32'd0);
        chk({nm, "_fault"}, 32'(fault), 32'd0);
        chk({nm, "_perr"},  32'(parity_err), 32'd0);
    endtask

    initial begin
        fvec[0] = '{1'b1, 10'd0, 1'b1, 10'h370, 1'b0};
        fvec[1] = '{1'b1, 10'd1, 1'b1, 10'h36D, 1'b0};
        fvec[2] = '{1'b1, 10'd2, 1'b1, 10'h029, 1'b0};
        fvec[3] = '{1'b0, 10'd0, 1'b0, 10'h029, 1'b0};
        fvec[4] = '{1'b1, 10'd5, 1'b1, HALT,    1'b1};
        fvec[5] = '{1'b0, 10'd0, 1'b0, HALT,    1'b1};
        fvec[6] = '{1'b1, 10'd1, 1'b1, 10'h36D, 1'b1};
        fvec[7] = '{1'b1, 10'd3, 1'b1, HALT,    1'b1};

        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();
        chk("empty_ready", 32'(fetch_ready), 32'd0);

        // basic three-word load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start_busy", 32'(load_busy), 32'd1);
        chk("start_wc", 32'(word_count), 32'd0);
        chk("load_ready", 32'(fetch_ready), 32'd0);
        lw(10'h370, 1'b0);
        lw(10'h36D, 1'b0);
        chk("mid_wc", 32'(word_count), 32'd2);
        chk("mid_busy", 32'(load_busy), 32'd1);
        lw(10'h029, 1'b1);
        chk("run_wc", 32'(word_count), 32'd3);
        chk("run_busy", 32'(load_busy), 32'd0);
        chk("run_ready", 32'(fetch_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            fetch_req  = fvec[i].req;
            fetch_addr = fvec[i].addr;
            step();
            fetch_req = 1'b0;
            chk($sformatf("vec%0d_rv", i), 32'(read_valid), 32'(fvec[i].exp_rv));
            chk($sformatf("vec%0d_rd", i), 32'(read_data), 32'(fvec[i].exp_rd));
            chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(fvec[i].exp_fault));
            chk($sformatf("vec%0d_perr", i), 32'(parity_err), 32'd0);
        end

        // fetch in flight when load_start arrives still completes
        fetch_req  = 1'b1;
        fetch_addr = 10'd0;
        step();
        fetch_req  = 1'b0;
        load_start = 1'b1;
        #1;
        chk("ls_ready", 32'(fetch_ready), 32'd0);
        chk("ls_rv", 32'(read_valid), 32'd1);
        chk("ls_rd", 32'(read_data), 32'h370);
        step();
        load_start = 1'b0;
        chk("ls_fault_clr", 32'(fault), 32'd0);
        chk("ls_wc_clr", 32'(word_count), 32'd0);
        chk("ls_busy", 32'(load_busy), 32'd1);
        chk("ls_rv_after", 32'(read_valid), 32'd0);

        // overflow: six words into a four-word store
        lw(10'h101, 1'b0);
        lw(10'h102, 1'b0);
        lw(10'h103, 1'b0);
        lw(10'h104, 1'b0);
        chk("full_wc", 32'(word_count), 32'd4);
        chk("full_fault", 32'(fault), 32'd0);
        lw(10'h105, 1'b0);
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_wc", 32'(word_count), 32'd4);
        chk("ovf_busy", 32'(load_busy), 32'd1);
        lw(10'h106, 1'b1);
        chk("ovf_run_busy", 32'(load_busy), 32'd0);
        chk("ovf_run_wc", 32'(word_count), 32'd4);
        fetch_chk("ovf_f3", 10'd3, 10'h104, 1'b1);
        fetch_chk("ovf_f0", 10'd0, 10'h101, 1'b1);

        // load_start with a word in the same cycle writes address 0
        load_start = 1'b1;
        lw(10'h3AA, 1'b0);
        load_start = 1'b0;
        chk("sim_wc", 32'(word_count), 32'd1);
        chk("sim_fault", 32'(fault), 32'd0);
        chk("sim_busy", 32'(load_busy), 32'd1);
        lw(10'h155, 1'b1);
        chk("sim_run_wc", 32'(word_count), 32'd2);
        fetch_chk("sim_f0", 10'd0, 10'h3AA, 1'b0);
        fetch_chk("sim_f1", 10'd1, 10'h155, 1'b0);

        // reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        lw(10'h011, 1'b0);
        lw(10'h022, 1'b0);
        reset = 1'b1;
        step();
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        step();
        load_start = 1'b1;
        lw(10'h2C3, 1'b0);
        load_start = 1'b0;
        lw(10'h0F0, 1'b1);
        chk("reld_wc", 32'(word_count), 32'd2);
        fetch_chk("reld_f0", 10'd0, 10'h2C3, 1'b0);
        fetch_chk("reld_f1", 10'd1, 10'h0F0, 1'b0);
        chk("reld_perr", 32'(parity_err), 32'd0);
        fetch_chk("reld_f2", 10'd2, HALT, 1'b1);

`ifdef IMEM_PARITY_EN
        dut.u_ram.mem[1] = dut.u_ram.mem[1] ^ 11'd1;
        fetch_chk("par_f1", 10'd1, 10'h0F1, 1'b1);
        chk("par_err", 32'(parity_err), 32'd1);
        step();
        chk("par_sticky", 32'(parity_err), 32'd1);
`else
        fetch_chk("nopar_f1", 10'd1, 10'h0F0, 1'b1);
        chk("nopar_err", 32'(parity_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
